cplx_corr_accumulator: RTL

- Downstream of the complex multiplier in the cross-correlation datapath.
- Consumes the stream of 32-bit re/im products and integrates FRAME_LEN valid products per correlation frame into wide accumulators.
- Presents each frame's complex sum through a valid/ready output with a sticky overrun flag.
- Frames run back-to-back from start until a stop request takes effect at a frame boundary.

---
 rtl/cplx_corr_accumulator.sv | 116 +++++++++++
 1 files changed

// File: rtl/cplx_corr_accumulator.sv
// cplx_corr_accumulator: integrates FRAME_LEN complex products per frame and
// presents each frame sum on a valid/ready output with a sticky overrun flag.
`default_nettype none

module cplx_corr_accumulator #(
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 48,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_re,
  output logic [ACC_W-1:0]  out_im,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc_re;
  logic [ACC_W-1:0]  acc_im;
  logic              stop_pend;

  logic [ACC_W-1:0]  ext_re;
  logic [ACC_W-1:0]  ext_im;
  logic [ACC_W-1:0]  sum_re;
  logic [ACC_W-1:0]  sum_im;
  logic              frame_end;

  assign ext_re    = ACC_W'($signed(in_re));
  assign ext_im    = ACC_W'($signed(in_im));
  assign sum_re    = acc_re + ext_re;
  assign sum_im    = acc_im + ext_im;
  assign frame_end = in_valid && (sample_cnt == CNT_LAST);
  assign busy      = (state == S_ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      acc_re     <= '0;
      acc_im     <= '0;
      out_re     <= '0;
      out_im     <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      // A result loaded below overrides this consumption clear.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ACCUM;
            acc_re     <= '0;
            acc_im     <= '0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
            stop_pend  <= 1'b0;
          end
        end

        S_ACCUM: begin
          if (start) begin
            acc_re     <= '0;
            acc_im     <= '0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
            stop_pend  <= 1'b0;
          end else if (frame_end) begin
            out_re     <= sum_re;
            out_im     <= sum_im;
            out_valid  <= 1'b1;
            acc_re     <= '0;
            acc_im     <= '0;
            sample_cnt <= '0;
            if (out_valid && !out_ready) overrun <= 1'b1;
            if (stop_pend || stop) begin
              state     <= S_IDLE;
              stop_pend <= 1'b0;
            end
          end else begin
            if (in_valid) begin
              acc_re     <= sum_re;
              acc_im     <= sum_im;
              sample_cnt <= sample_cnt + CNT_ONE;
            end
            if (stop) stop_pend <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
